// File: rtl/rv32i_cpu_lsu.sv
// RV32I load/store unit: one outstanding request, byte-addressed RAM port with
// a registered read path, fault detection for illegal width, misalignment and range.
module rv32i_cpu_lsu #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_value,
    input  logic [31:0]           mem_value
);

    localparam logic [1:0] MEM_READ       = 2'd0;
    localparam logic [1:0] MEM_WRITE_WORD = 2'd1;
    localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
    localparam logic [1:0] MEM_WRITE_BYTE = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  we_r;
    logic [2:0]            funct3_r;
    logic                  resp_valid_r;
    logic [31:0]           resp_rdata_r;
    logic                  resp_err_r;
    logic [1:0]            mem_mode_r;
    logic [ADDR_WIDTH-1:0] mem_address_r;
    logic [31:0]           mem_write_value_r;
    logic                  fault_s;

    function automatic logic req_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        logic misalign;
        logic oob;
        if (we) begin
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        if (f3[1:0] == 2'b01) begin
            misalign = addr[0];
        end else if (f3[1:0] == 2'b10) begin
            misalign = (addr[1:0] != 2'b00);
        end else begin
            misalign = 1'b0;
        end
        oob = ((addr >> ADDR_WIDTH) != 32'd0);
        return bad_f3 | misalign | oob;
    endfunction

    function automatic logic [1:0] store_mode(input logic [2:0] f3);
        case (f3)
            3'b000:  return MEM_WRITE_BYTE;
            3'b001:  return MEM_WRITE_HALF;
            3'b010:  return MEM_WRITE_WORD;
            default: return MEM_READ;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  return {24'd0, wd[7:0]};
            3'b001:  return {16'd0, wd[15:0]};
            3'b010:  return wd;
            default: return 32'd0;
        endcase
    endfunction

    // RAM presents the lowest-addressed byte on the top lane, so lanes are reversed here.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [31:0] mv);
        case (f3)
            3'b000:  return {{24{mv[31]}}, mv[31:24]};
            3'b100:  return {24'd0, mv[31:24]};
            3'b001:  return {{16{mv[23]}}, mv[23:16], mv[31:24]};
            3'b101:  return {16'd0, mv[23:16], mv[31:24]};
            3'b010:  return {mv[7:0], mv[15:8], mv[23:16], mv[31:24]};
            default: return 32'd0;
        endcase
    endfunction

    assign fault_s = req_fault(req_we, req_funct3, req_addr);

    // Next-state decode for the request/response sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = fault_s ? RESP : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE:   state_s = we_r ? RESP : WAIT;
            WAIT:    state_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered request context, RAM command and response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r           <= IDLE;
            we_r              <= 1'b0;
            funct3_r          <= 3'd0;
            resp_valid_r      <= 1'b0;
            resp_rdata_r      <= 32'd0;
            resp_err_r        <= 1'b0;
            mem_mode_r        <= MEM_READ;
            mem_address_r     <= {ADDR_WIDTH{1'b0}};
            mem_write_value_r <= 32'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        we_r     <= req_we;
                        funct3_r <= req_funct3;
                        if (fault_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'd0;
                        end else begin
                            mem_mode_r        <= req_we ? store_mode(req_funct3) : MEM_READ;
                            mem_address_r     <= req_addr[ADDR_WIDTH-1:0];
                            mem_write_value_r <= req_we ? store_data(req_funct3, req_wdata) : 32'd0;
                        end
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_mode_r        <= MEM_READ;
                    mem_address_r     <= {ADDR_WIDTH{1'b0}};
                    mem_write_value_r <= 32'd0;
                    if (we_r) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                WAIT: begin
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_format(funct3_r, mem_value);
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'd0;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // The RAM acts on the edge that ends ISSUE; masking with rst keeps a store
    // from landing on the very edge that resets the LSU.
    assign mem_mode        = rst ? mem_mode_r : MEM_READ;
    assign mem_address     = rst ? mem_address_r : {ADDR_WIDTH{1'b0}};
    assign mem_write_value = rst ? mem_write_value_r : 32'd0;

endmodule
